// File: rtl/cpu_clock_ctrl_if.sv
// Control/status bundle between the CPU clock controller and its environment.
// The controller takes the slave side; the environment driving run/step/halt/clear takes the master side.
interface cpu_clock_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             inp_run;
    logic             inp_step;
    logic             inp_halt_req;
    logic             inp_clear;
    logic             out_cpu_en;
    logic [1:0]       out_state;
    logic [CNT_W-1:0] out_cycle_cnt;
    logic             out_halted;

    modport master (
        output inp_run, inp_step, inp_halt_req, inp_clear,
        input  out_cpu_en, out_state, out_cycle_cnt, out_halted
    );

    modport slave (
        input  inp_run, inp_step, inp_halt_req, inp_clear,
        output out_cpu_en, out_state, out_cycle_cnt, out_halted
    );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable controller: free-running divided strobe in RUN, debounced single step,
// halt/clear handling and a wrapping count of issued strobes. All outputs are registered.
module cpu_clock_ctrl #(
    parameter int DIV       = 4,
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             inp_clk,
    input  logic             inp_rst_n,
    cpu_clock_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RUN    = 2'b01;
    localparam logic [1:0] ST_STEP   = 2'b10;
    localparam logic [1:0] ST_HALTED = 2'b11;
    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
    localparam logic [7:0] DB_LAST   = 8'(DB_CYCLES - 1);

    logic [1:0]       run_sync_r;
    logic [1:0]       step_sync_r;
    logic             run_s;
    logic             step_s;
    logic             db_r;
    logic             db_prev_r;
    logic [7:0]       db_cnt_r;
    logic             step_pulse_s;
    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [7:0]       div_r;
    logic [7:0]       div_next_s;
    logic             en_r;
    logic             en_next_s;
    logic             halted_r;
    logic             halted_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    assign run_s        = run_sync_r[1];
    assign step_s       = step_sync_r[1];
    assign step_pulse_s = db_r & ~db_prev_r;

    // Two-flop synchronizers for the asynchronous run switch and step button.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            run_sync_r  <= 2'b00;
            step_sync_r <= 2'b00;
        end else begin
            run_sync_r  <= {run_sync_r[0], bus.inp_run};
            step_sync_r <= {step_sync_r[0], bus.inp_step};
        end
    end

    // Debounce: db follows step_s only after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            db_r      <= 1'b0;
            db_prev_r <= 1'b0;
            db_cnt_r  <= 8'd0;
        end else begin
            db_prev_r <= db_r;
            if (step_s == db_r) begin
                db_cnt_r <= 8'd0;
            end else if (db_cnt_r == DB_LAST) begin
                db_r     <= step_s;
                db_cnt_r <= 8'd0;
            end else begin
                db_cnt_r <= db_cnt_r + 8'd1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; clear outranks everything, HALTED ignores all but clear.
    always_comb begin
        next_state_s = state_r;
        if (bus.inp_clear) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_state_s = run_s ? ST_RUN : (step_pulse_s ? ST_STEP : ST_IDLE);
                ST_RUN:    next_state_s = bus.inp_halt_req ? ST_HALTED : (run_s ? ST_RUN : ST_IDLE);
                ST_STEP:   next_state_s = bus.inp_halt_req ? ST_HALTED : ST_IDLE;
                ST_HALTED: next_state_s = ST_HALTED;
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode evaluated on next-state values so the registered outputs line up with state_r.
    always_comb begin
        div_next_s = 8'd0;
        if (state_r == ST_RUN && next_state_s == ST_RUN) begin
            div_next_s = (div_r == DIV_LAST) ? 8'd0 : div_r + 8'd1;
        end else begin
            div_next_s = 8'd0;
        end
        en_next_s     = (next_state_s == ST_STEP) ||
                        ((next_state_s == ST_RUN) && (div_next_s == DIV_LAST));
        halted_next_s = (next_state_s == ST_HALTED);
        if (bus.inp_clear) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (en_r) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Output and divider registers.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            div_r    <= 8'd0;
            en_r     <= 1'b0;
            halted_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            div_r    <= div_next_s;
            en_r     <= en_next_s;
            halted_r <= halted_next_s;
            cnt_r    <= cnt_next_s;
        end
    end

    assign bus.out_cpu_en    = en_r;
    assign bus.out_state     = state_r;
    assign bus.out_cycle_cnt = cnt_r;
    assign bus.out_halted    = halted_r;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Scoreboard bench for cpu_clock_ctrl: two instances (DIV=4/DB=8/CNT_W=16 and DIV=1/DB=2/CNT_W=4)
// share stimulus; a cycle-level reference model feeds expectation queues drained by a monitor.
module tb_cpu_clock_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic step = 1'b0;
    logic halt_req = 1'b0;
    logic clear = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_clock_ctrl_if #(.CNT_W(16)) ifa ();
    cpu_clock_ctrl_if #(.CNT_W(4))  ifb ();

    assign ifa.inp_run = run;      assign ifb.inp_run = run;
    assign ifa.inp_step = step;    assign ifb.inp_step = step;
    assign ifa.inp_halt_req = halt_req; assign ifb.inp_halt_req = halt_req;
    assign ifa.inp_clear = clear;  assign ifb.inp_clear = clear;

    cpu_clock_ctrl #(.DIV(4), .DB_CYCLES(8), .CNT_W(16)) dut_a (
        .inp_clk(clk), .inp_rst_n(rst_n), .bus(ifa));
    cpu_clock_ctrl #(.DIV(1), .DB_CYCLES(2), .CNT_W(4)) dut_b (
        .inp_clk(clk), .inp_rst_n(rst_n), .bus(ifb));

    // Reference model: mode 0=IDLE 1=RUN 2=STEP 3=HALTED, phase = RUN cycles since entry mod DIV.
    int m_mode[2];
    int m_phase[2];
    int m_cnt[2];
    int m_streak[2];
    bit m_db[2];
    bit m_dbp[2];
    bit m_run_1[2];
    bit m_run_s[2];
    bit m_step_1[2];
    bit m_step_s[2];

    typedef struct {
        bit en;
        int st;
        int cnt;
        bit halted;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int db_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic int w_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic bit strobe(input int i);
        return (m_mode[i] == 2) || (m_mode[i] == 1 && m_phase[i] == div_of(i) - 1);
    endfunction

    task automatic model_reset(input int i);
        m_mode[i] = 0; m_phase[i] = 0; m_cnt[i] = 0; m_streak[i] = 0;
        m_db[i] = 1'b0; m_dbp[i] = 1'b0;
        m_run_1[i] = 1'b0; m_run_s[i] = 1'b0; m_step_1[i] = 1'b0; m_step_s[i] = 1'b0;
    endtask

    task automatic model_step(input int i);
        bit en_old;
        bit pulse;
        int nm;
        en_old = strobe(i);
        pulse  = m_db[i] && !m_dbp[i];
        if (clear) nm = 0;
        else begin
            case (m_mode[i])
                0:       nm = m_run_s[i] ? 1 : (pulse ? 2 : 0);
                1:       nm = halt_req ? 3 : (m_run_s[i] ? 1 : 0);
                2:       nm = halt_req ? 3 : 0;
                default: nm = 3;
            endcase
        end
        m_phase[i] = (nm == 1 && m_mode[i] == 1) ? (m_phase[i] + 1) % div_of(i) : 0;
        m_mode[i]  = nm;
        m_cnt[i]   = clear ? 0 : (m_cnt[i] + (en_old ? 1 : 0)) % (1 << w_of(i));
        m_dbp[i]   = m_db[i];
        if (m_step_s[i] != m_db[i]) begin
            m_streak[i] = m_streak[i] + 1;
            if (m_streak[i] >= db_of(i)) begin
                m_db[i] = m_step_s[i];
                m_streak[i] = 0;
            end
        end else begin
            m_streak[i] = 0;
        end
        m_step_s[i] = m_step_1[i]; m_step_1[i] = step;
        m_run_s[i]  = m_run_1[i];  m_run_1[i]  = run;
    endtask

    function automatic exp_t expect_of(input int i);
        exp_t e;
        e.en = strobe(i); e.st = m_mode[i]; e.cnt = m_cnt[i]; e.halted = (m_mode[i] == 3);
        return e;
    endfunction

    // One clock: advance the model on the same edge as the DUTs, queue the expectation, then step off the edge.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i);
        end
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
        #1;
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic en, input logic [1:0] st,
                       input int cnt, input logic h);
        checks++;
        if (en !== e.en || int'(st) != e.st || cnt != e.cnt || h !== e.halted) begin
            failures++;
            $display("FAIL %s t=%0t: got en=%0b st=%0d cnt=%0d halted=%0b, expected en=%0b st=%0d cnt=%0d halted=%0b",
                     nm, $time, en, st, cnt, h, e.en, e.st, e.cnt, e.halted);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Monitor: every cycle the DUTs present outputs; pop and compare on the inactive edge.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("scoreboard_a", e, ifa.out_cpu_en, ifa.out_state, int'(ifa.out_cycle_cnt), ifa.out_halted);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("scoreboard_b", e, ifb.out_cpu_en, ifb.out_state, int'(ifb.out_cycle_cnt), ifb.out_halted);
        end
    end

    task automatic wait_strobe_a(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            seen = strobe(0) && (m_mode[0] == 1);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: got no RUN strobe within 40 cycles, expected one", nm);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
        repeat (3) tick();
        chk("reset_en_a", int'(ifa.out_cpu_en), 0);
        chk("reset_state_a", int'(ifa.out_state), 0);
        chk("reset_cnt_a", int'(ifa.out_cycle_cnt), 0);
        chk("reset_halted_a", int'(ifa.out_halted), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Continuous RUN for 20 cycles, then drop run.
        run = 1'b1;
        repeat (20) tick();
        run = 1'b0;
        repeat (6) tick();
        chk("run20_state_a", int'(ifa.out_state), 0);
        chk("run20_cnt_a", int'(ifa.out_cycle_cnt), 5);
        chk("run20_cnt_b_wrapped", int'(ifb.out_cycle_cnt), 4);

        // Counter wrap on the DIV=1 / 4-bit instance over 17 RUN cycles.
        pulse_clear();
        chk("clear_cnt_a", int'(ifa.out_cycle_cnt), 0);
        run = 1'b1;
        repeat (17) tick();
        run = 1'b0;
        repeat (6) tick();
        chk("wrap17_cnt_b", int'(ifb.out_cycle_cnt), 1);
        chk("wrap17_cnt_a", int'(ifa.out_cycle_cnt), 4);

        // Bouncing step button, then a long hold: one strobe on instance A.
        pulse_clear();
        for (int k = 0; k < 30; k++) begin
            step = ((k / 3) % 2 == 0);
            tick();
        end
        step = 1'b1;
        repeat (40) tick();
        step = 1'b0;
        repeat (20) tick();
        chk("step_once_cnt_a", int'(ifa.out_cycle_cnt), 1);

        // Halt raised on a strobe cycle, inputs ignored while halted, clear releases.
        pulse_clear();
        run = 1'b1;
        wait_strobe_a("halt_wait_strobe");
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("halt_state_a", int'(ifa.out_state), 3);
        chk("halt_flag_a", int'(ifa.out_halted), 1);
        chk("halt_en_a", int'(ifa.out_cpu_en), 0);
        for (int k = 0; k < 20; k++) begin
            run  = 1'($urandom_range(0, 1));
            step = 1'($urandom_range(0, 1));
            tick();
        end
        chk("halt_hold_state_a", int'(ifa.out_state), 3);
        run = 1'b0;
        step = 1'b0;
        pulse_clear();
        chk("halt_clear_state_a", int'(ifa.out_state), 0);
        chk("halt_clear_cnt_a", int'(ifa.out_cycle_cnt), 0);
        chk("halt_clear_state_b", int'(ifb.out_state), 0);
        repeat (15) tick();

        // run_s and step_pulse arriving together in IDLE: RUN wins, no STEP strobe.
        step = 1'b1;
        repeat (8) tick();
        run = 1'b1;
        repeat (3) tick();
        chk("both_state_a", int'(ifa.out_state), 1);
        chk("both_en_a", int'(ifa.out_cpu_en), 0);
        run = 1'b0;
        step = 1'b0;
        repeat (15) tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 5) == 0) step = ~step;
            halt_req = ($urandom_range(0, 29) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            tick();
        end
        halt_req = 1'b0;
        clear = 1'b0;
        run = 1'b0;
        step = 1'b0;
        repeat (20) tick();

        // Asynchronous reset landing inside a strobe cycle.
        pulse_clear();
        run = 1'b1;
        wait_strobe_a("rst_wait_strobe");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        #1;
        chk("rst_mid_en_a", int'(ifa.out_cpu_en), 0);
        chk("rst_mid_state_a", int'(ifa.out_state), 0);
        chk("rst_mid_cnt_a", int'(ifa.out_cycle_cnt), 0);
        chk("rst_mid_en_b", int'(ifb.out_cpu_en), 0);
        chk("rst_mid_cnt_b", int'(ifb.out_cycle_cnt), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        run = 1'b0;
        repeat (8) tick();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4: RUN-mode enable period in inp_clk cycles; legal range 1..255.
REQ-002 SHALL have parameter DB_CYCLES, default 8: debounce stability window in cycles; legal range 2..255.
REQ-003 SHALL have parameter CNT_W, default 16: width of the issued-enable counter.
REQ-004 SHALL have port inp_clk, input, 1 bit: the single clock, which is the artificialClock out_clk; all logic on the rising edge.
REQ-005 SHALL have port inp_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port inp_run, input, 1 bit: asynchronous run switch level.
REQ-007 SHALL have port inp_step, input, 1 bit: asynchronous raw single-step button, which bounces.
REQ-008 SHALL have port inp_halt_req, input, 1 bit: synchronous halt request from the core.
REQ-009 SHALL have port inp_clear, input, 1 bit: synchronous clear.
REQ-010 SHALL have port out_cpu_en, output, 1 bit: one-cycle clock-enable strobe to the RISC core.
REQ-011 SHALL have port out_state, output, 2 bits: FSM state encoded as IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-012 SHALL have port out_cycle_cnt, output, CNT_W bits: count of strobes issued.
REQ-013 SHALL have port out_halted, output, 1 bit: high while out_state==HALTED.

Function
REQ-014 SHALL pass inp_run and inp_step each through a 2-flop synchronizer (run_s, step_s) before any use.
REQ-015 SHALL debounce step_s: the debounced level db changes only after step_s differs from db for DB_CYCLES consecutive cycles; any cycle with step_s==db zeroes the debounce counter.
REQ-016 SHALL generate step_pulse for exactly one cycle on each 0->1 transition of db; a held button SHALL produce only one pulse.
REQ-017 SHALL have IDLE go to RUN if run_s=1, else to STEP if step_pulse=1; with both set, SHALL take RUN and discard the step.
REQ-018 SHALL have STEP last exactly one cycle, then go to HALTED if inp_halt_req=1, else to IDLE.
REQ-019 SHALL have RUN go to HALTED on inp_halt_req=1 and to IDLE on run_s=0; halt SHALL have priority over run_s=0.
REQ-020 SHALL hold HALTED until inp_clear=1; run_s, step_pulse and inp_halt_req SHALL be ignored in HALTED.
REQ-021 SHALL, on inp_clear=1 in any state, force next state IDLE, div_cnt 0 and out_cycle_cnt 0; clear SHALL have priority over all other transitions.
REQ-022 SHALL keep div_cnt in 0..DIV-1: it increments each RUN cycle, wraps DIV-1->0, and is forced to 0 in every non-RUN state.
REQ-023 SHALL decode out_cpu_en as (state==STEP) OR (state==RUN AND div_cnt==DIV-1), from registered signals only, with no combinational path from any input.
REQ-024 SHALL, with DIV=1, hold out_cpu_en high on every RUN cycle.
REQ-025 SHALL still issue the strobe in a RUN cycle that has div_cnt==DIV-1 and inp_halt_req=1; the following cycle SHALL be HALTED with out_cpu_en=0.
REQ-026 SHALL increment out_cycle_cnt in every cycle with out_cpu_en=1, modulo 2^CNT_W, wrapping all-ones -> 0 without saturation.
REQ-027 SHALL let step_pulse events occurring outside IDLE be lost, with no queuing.

Reset
REQ-028 SHALL, on inp_rst_n=0, immediately and asynchronously set out_cpu_en=0, out_state=IDLE, out_halted=0, out_cycle_cnt=0, div_cnt=0, synchronizers=0, db=0 and debounce counter=0.
REQ-029 SHALL release reset synchronously to inp_clk, so the first state change can occur on the first rising edge after inp_rst_n=1.
REQ-030 SHALL, on reset asserted mid-RUN or mid-STEP, suppress any in-progress strobe in the same instant, with no strobe issued until after release.

Verification
REQ-031 SHALL be verified with DIV=4 and inp_run held at 1 for 20 cycles: expect out_cpu_en pulses every 4th cycle and out_cycle_cnt increasing by 1 per pulse, and after inp_run drops, IDLE within 3 cycles with no further pulses.
REQ-032 SHALL be verified with DB_CYCLES=8 and inp_step bouncing 0/1 every 3 cycles for 30 cycles, then held at 1 for 40 cycles: expect no strobe during bounce, then exactly one out_cpu_en pulse and out_cycle_cnt +1.
REQ-033 SHALL be verified in RUN with DIV=4 and inp_halt_req pulsed on the div_cnt==3 cycle: expect a strobe in that cycle, then out_state=11 with out_halted=1, with toggling inp_run and inp_step causing no change until inp_clear=1, which gives IDLE and count 0.
REQ-034 SHALL be verified with CNT_W=4 and DIV=1 in RUN for 17 cycles: expect out_cycle_cnt to wrap 15->0 and end at 1.
REQ-035 SHALL be verified with inp_rst_n driven low between clock edges during RUN on a strobe cycle: expect out_cpu_en=0 and all outputs at reset values before the next edge.
REQ-036 SHALL be verified with run_s and step_pulse both rising in the same IDLE cycle: expect entry to RUN and no STEP strobe.
